// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide sequencer.
//   - op encodings as presented on muldiv_ctrl.op
//   - FSM state encoding used by muldiv_ctrl
//   - default iteration count (one iteration per operand bit)
package muldiv_pkg;

    localparam int ITER_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   acc     : upper half (multiply partial product / divide remainder)
//   shreg   : lower half (multiplier bits / dividend bits -> quotient bits)
//   operand : multiplicand (multiply) or divisor (divide), both unsigned
//   mode    : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_nxt, sh_nxt : the acc/shift pair after this iteration
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] shreg,
    input  logic [DATA_W-1:0] operand,
    input  logic              mode,
    output logic [DATA_W-1:0] acc_nxt,
    output logic [DATA_W-1:0] sh_nxt
);

    logic [DATA_W:0]   sum;
    logic [DATA_W+1:0] trial;

    always_comb begin
        // Multiply: add operand when the current multiplier bit is set, then
        // shift the whole {carry, acc, shreg} right by one.
        sum = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
        // Divide: shift the next dividend bit into the remainder and try the
        // subtraction; one extra guard bit gives an unambiguous sign.
        trial = {1'b0, acc, shreg[DATA_W-1]} - {2'b00, operand};
        if (mode) begin
            if (!trial[DATA_W+1])
                acc_nxt = trial[DATA_W-1:0];
            else
                acc_nxt = {acc[DATA_W-2:0], shreg[DATA_W-1]};
            sh_nxt = {shreg[DATA_W-2:0], ~trial[DATA_W+1]};
        end else begin
            acc_nxt = sum[DATA_W:1];
            sh_nxt  = {sum[0], shreg[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative mult/multu/div/divu sequencer owning HI/LO.
//   clk, reset        : clock, synchronous active-high reset
//   start, op         : operation issue from EX (00 mult, 01 multu, 10 div, 11 divu)
//   rs_val, rt_val    : operand A (multiplicand/dividend), operand B
//   rd_req            : mfhi/mflo in EX
//   mthi, mtlo, wdata : direct HI/LO writes
//   busy              : operation in flight (RUN or FIX)
//   stall             : pipeline hold request while busy
//   done              : one-cycle pulse after HI/LO take an operation result
//   div_zero          : sticky flag, last div/divu had a zero divisor
//   hi, lo            : HI/LO registers
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ITER   = ITER_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              rd_req,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CW = $clog2(ITER);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] acc, sh, opb, a_raw;
    logic              neg_q, neg_r, is_div;

    logic [DATA_W-1:0]   acc_nxt, sh_nxt;
    logic [2*DATA_W-1:0] prod, prod_s;
    logic [DATA_W-1:0]   hi_fix, lo_fix;
    logic                a_neg, b_neg;

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .acc     (acc),
        .shreg   (sh),
        .operand (opb),
        .mode    (is_div),
        .acc_nxt (acc_nxt),
        .sh_nxt  (sh_nxt)
    );

    // Signed ops (op[0]==0) run on magnitudes; signs are restored in FIX.
    assign a_neg = ~op[0] & rs_val[DATA_W-1];
    assign b_neg = ~op[0] & rt_val[DATA_W-1];

    always_comb begin
        prod   = {acc, sh};
        prod_s = neg_q ? -prod : prod;
        if (is_div) begin
            if (opb == '0) begin
                hi_fix = a_raw;
                lo_fix = '1;
            end else begin
                lo_fix = neg_q ? -sh  : sh;
                hi_fix = neg_r ? -acc : acc;   // remainder follows dividend sign
            end
        end else begin
            {hi_fix, lo_fix} = prod_s;
        end
    end

    assign stall = busy & (start | rd_req | mthi | mtlo);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            sh       <= '0;
            opb      <= '0;
            a_raw    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        sh     <= a_neg ? -rs_val : rs_val;
                        opb    <= b_neg ? -rt_val : rt_val;
                        a_raw  <= rs_val;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        is_div <= op[1];
                        cnt    <= CW'(ITER - 1);
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                ST_RUN: begin
                    acc <= acc_nxt;
                    sh  <= sh_nxt;
                    if (cnt == '0)
                        state <= ST_FIX;
                    else
                        cnt <= cnt - CW'(1);
                end
                ST_FIX: begin
                    hi    <= hi_fix;
                    lo    <= lo_fix;
                    if (is_div) div_zero <= (opb == '0);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed + randomized check of muldiv_ctrl against a
// plain-arithmetic reference of the MIPS mult/div semantics.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, rd_req, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wdata;
    logic        busy, stall, done, div_zero;
    logic [31:0] hi, lo;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic dz_m  = 1'b0;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .rd_req(rd_req),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .stall(stall), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: {hi, lo} for an operation, from 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return 64'(ua * ub);
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered on the first negedge after the start edge; follows the op to completion.
    task automatic finish_op(input string tag, input logic [63:0] exp);
        int bc, dc;
        bc = 0; dc = 0;
        repeat (40) begin
            if (busy) bc++;
            if (done) dc++;
            @(negedge clk);
        end
        chk({tag, " hi:lo"}, {hi, lo}, exp);
        chk({tag, " busy cycles"}, 64'(bc), 64'd33);
        chk({tag, " done pulses"}, 64'(dc), 64'd1);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        finish_op(tag, model(o, a, b));
        if (o[1]) dz_m = (b == 32'd0);
        chk({tag, " div_zero"}, 64'(div_zero), 64'(dz_m));
    endtask

    initial begin
        logic [31:0] a1, b1, a2, b2, lo_prev;
        logic [1:0]  ro;
        int          sc, dc;
        logic        idle;

        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        rd_req = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset div_zero", 64'(div_zero), 64'd0);
        chk("reset hi:lo", {hi, lo}, 64'd0);
        reset = 1'b0;

        // Directed cases with hand-derived results
        do_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5);
        chk("mult -3*5 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("div -7/2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div min/-1 const", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op("divu 100/0", 2'b11, 32'd100, 32'd0);
        chk("divu 100/0 const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        chk("divu 100/0 dz set", 64'(div_zero), 64'd1);
        do_op("divu 9/3", 2'b11, 32'd9, 32'd3);
        chk("divu 9/3 const", {hi, lo}, 64'h0000_0000_0000_0003);
        chk("divu 9/3 dz clear", 64'(div_zero), 64'd0);

        // mthi+mtlo together in IDLE, with rd_req: no stall
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; rd_req = 1'b1; wdata = 32'hCAFE_F00D;
        #1 chk("idle stall", 64'(stall), 64'd0);
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; rd_req = 1'b0;
        chk("mthi+mtlo", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);

        // start has priority over a simultaneous mtlo
        @(negedge clk);
        lo_prev = lo;
        start = 1'b1; op = 2'b00; rs_val = 32'd7; rt_val = 32'hFFFF_FFFA; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        chk("start over mtlo", 64'(lo), 64'(lo_prev));
        finish_op("mult 7*-6", model(2'b00, 32'd7, 32'hFFFF_FFFA));

        // Randomized operations
        for (int i = 0; i < 14; i++) begin
            ro = 2'($urandom_range(0, 3));
            a1 = $urandom;
            b1 = $urandom;
            if ($urandom_range(0, 3) == 0) a1 = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0: b1 = 32'd0;
                1: b1 = 32'hFFFF_FFFF;
                2: b1 = 32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op("random", ro, a1, b1);
        end

        // Stall: rd_req from 2 cycles after start, second start held during busy
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = a1; rt_val = b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'b10; rs_val = a2; rt_val = b2; rd_req = 1'b1;
        sc = 0; idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            #1;
            if (busy) begin
                chk("stall while busy", 64'(stall), 64'd1);
                sc++;
                @(negedge clk);
            end else begin
                idle = 1'b1;
            end
        end
        chk("returned to idle", 64'(idle), 64'd1);
        chk("stall cycles", 64'(sc), 64'd32);
        chk("done-cycle stall", 64'(stall), 64'd0);
        chk("done-cycle done", 64'(done), 64'd1);
        chk("done-cycle hi:lo", {hi, lo}, model(2'b00, a1, b1));
        @(negedge clk);
        start = 1'b0; rd_req = 1'b0; rs_val = $urandom; rt_val = $urandom;
        chk("second op busy", 64'(busy), 64'd1);
        finish_op("held div", model(2'b10, a2, b2));
        dz_m = 1'b0;

        // Reset mid-operation
        do_op("divu x/0", 2'b11, 32'h1357_9BDF, 32'd0);
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = 32'h1234_5678; rt_val = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset hi:lo", {hi, lo}, 64'd0);
        chk("midreset div_zero", 64'(div_zero), 64'd0);
        dc = 0;
        repeat (40) begin
            if (done) dc++;
            @(negedge clk);
        end
        chk("midreset no done", 64'(dc), 64'd0);
        chk("midreset hi:lo stays", {hi, lo}, 64'd0);
        mthi = 1'b1; wdata = 32'h0000_1234;
        #1 chk("mthi stall", 64'(stall), 64'd0);
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi hi", 64'(hi), 64'h1234);
        chk("mthi lo untouched", 64'(lo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative multiply/divide sequencer for the MIPS pipeline's EX stage. It executes mult/multu/div/divu over a fixed number of cycles and owns the HI/LO registers. It also services mfhi/mflo/mthi/mtlo. It drives a stall request, ORed into the control unit's stall input, so the pipeline holds while a result is pending.

Parameters:
DATA_W, 32, operand and HI/LO width
ITER, 32, iteration cycles per operation; must equal DATA_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  mult/multu/div/divu in EX this cycle
op  in  2  00 mult, 01 multu, 10 div, 11 divu
rs_val  in  DATA_W  operand A (multiplicand / dividend)
rt_val  in  DATA_W  operand B (multiplier / divisor)
rd_req  in  1  mfhi or mflo in EX
mthi  in  1  write HI from wdata
mtlo  in  1  write LO from wdata
wdata  in  DATA_W  mthi/mtlo data
busy  out  1  operation in flight
stall  out  1  pipeline hold request
done  out  1  one-cycle pulse after HI/LO are updated by an operation
div_zero  out  1  sticky: last div/divu had a zero divisor
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register

Behaviour:
- Clock and reset: all state on the rising edge of clk. Reset is synchronous, active-high.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
- Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- FSM states: IDLE, RUN, FIX.
- IDLE with start=1:
  - Latch |A|, |B| (signed ops) or A, B (unsigned ops).
  - Latch the result sign flags and op.
  - Load counter=ITER-1; go to RUN.
- RUN, multiply step: one shift-add per cycle.
- RUN, divide step: one restoring subtract per cycle.
- RUN exit: at counter==0 go to FIX; otherwise decrement the counter.
- FIX (one cycle):
  - Apply sign correction.
  - Write hi/lo at the FIX edge.
  - Go to IDLE; done=1 for the following cycle.
- Latency: start sampled at edge E0; hi/lo valid after edge E0+ITER+1 (33 cycles for ITER=32). done is high in the cycle after that edge.
- busy=1 in RUN and FIX; otherwise 0.
- stall = busy & (start | rd_req | mthi | mtlo), combinational.
  - stall is never asserted in IDLE.
  - In the done cycle, hi/lo already hold the new result, so mfhi/mflo proceed with no stall.
- start while busy is ignored (stall holds it in EX). It is accepted the cycle after return to IDLE.
- mthi/mtlo in IDLE: write hi/lo at the next edge.
  - If start=1 in the same cycle, start has priority and mthi/mtlo are dropped.
  - mthi and mtlo together write both registers.
- Multiply result: hi:lo = 64-bit product. Signed product = two's complement of the unsigned product when the operand signs differ.
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Special case 0x80000000 / -1: lo=0x80000000, hi=0.
- Divisor zero:
  - Operation still takes the full latency.
  - Result is lo=0xFFFFFFFF and hi=dividend (raw rs_val).
  - div_zero is set at the FIX edge.
  - div_zero is cleared at the FIX edge of any later div/divu with a nonzero divisor.
- Counter width is clog2(ITER); it is never compared outside 0..ITER-1.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - FSM state enum (ST_IDLE, ST_RUN, ST_FIX)
  - ITER default
- One sub-module, muldiv_step: a combinational single-iteration datapath.
  - Inputs: acc, operand, mode.
  - Outputs: the next acc/shift pair.
- muldiv_ctrl owns the FSM, the counter, the sign fixup, HI/LO and the stall logic.

Test Plan:
- Max unsigned multiply: multu with rs=0xFFFFFFFF, rt=0xFFFFFFFF.
  - Expect busy for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
  - Expect done pulsed exactly once.
- Signed multiply: mult with rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed divide, two cases:
  - div with rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div with rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: divu with rs=100, rt=0 -> lo=0xFFFFFFFF, hi=0x64, div_zero=1.
  - A following divu 9/3 gives lo=3, hi=0 and clears div_zero.
- Stall: rd_req held from 2 cycles after start -> stall=1 through the FIX cycle, then 0 in the done cycle.
  - A second start issued during busy runs only after IDLE, with its operands intact.
- Reset mid-operation: reset at cycle 10 of RUN -> next cycle busy=0, hi=lo=0, no done pulse.
  - A subsequent mthi with wdata=0x1234 in IDLE gives hi=0x1234 with no stall.
